// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared CPU definitions for the fetch stage.
//   fetch_state_e : fetch FSM encoding (IDLE / REQ / DISCARD)
//   INSTR_W       : instruction and PC width
//   PC_STEP       : byte increment between sequential instruction words
package instr_prefetch_buffer_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// Bus bundle between the prefetch buffer, the instruction memory and the CPU.
//   redirect_i / redirect_pc_i : taken branch or jump and its target
//   mem_req_o / mem_addr_o     : single outstanding word request
//   mem_ack_i / mem_data_i     : memory returns the requested word
//   instr_valid_o / instr_o / instr_pc_o / instr_ready_i : CPU side
//
// Handshakes:
//   memory: mem_req_o rises with mem_addr_o and both hold stable until the
//           cycle mem_ack_i is high; that cycle completes the transfer and
//           mem_data_i is taken. A request is never withdrawn.
//   CPU:    an instruction transfers on any rising edge where instr_valid_o
//           and instr_ready_i are both high; instr_ready_i is a don't-care
//           while instr_valid_o is low.
// The master modport is the fetch block, the slave modport is its environment.
interface instr_prefetch_buffer_if;
    import instr_prefetch_buffer_pkg::*;

    logic               redirect_i;
    logic [INSTR_W-1:0] redirect_pc_i;
    logic               mem_req_o;
    logic [INSTR_W-1:0] mem_addr_o;
    logic               mem_ack_i;
    logic [INSTR_W-1:0] mem_data_i;
    logic               instr_valid_o;
    logic [INSTR_W-1:0] instr_o;
    logic [INSTR_W-1:0] instr_pc_o;
    logic               instr_ready_i;

    modport master (
        input  redirect_i, redirect_pc_i, mem_ack_i, mem_data_i, instr_ready_i,
        output mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, mem_ack_i, mem_data_i, instr_ready_i,
        input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o
    );

endinterface

// File: rtl/instr_prefetch_buffer_sync_fifo.sv
// Synchronous FIFO with flush, reusable by other buffering blocks.
//   clk_i, rst_i (sync, active-low)
//   flush_i     : empties the FIFO; overrides a same-cycle push and pop
//   push_i      : writes push_data_i (caller guarantees space)
//   pop_i       : removes the head; ignored while empty
//   head_o      : current head entry (meaningful only when count_o != 0)
//   count_o     : number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW:0]      count_q;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage needs no reset; entries are only visible through count_q.
    always_ff @(posedge clk_i) begin
        if (rst_i && !flush_i && push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: owns the fetch PC, issues one word request at
// a time to a variable-latency instruction memory, queues {pc, instr} pairs
// and hands them to the CPU. A redirect flushes the queue and refetches.
//   clk_i, rst_i (sync, active-low)
//   bus     : instr_prefetch_buffer_if.master (redirect, memory, CPU sides)
//   state_o : current fetch FSM state, for observation only
module instr_prefetch_buffer
    import instr_prefetch_buffer_pkg::*;
#(
    parameter int                 DEPTH    = 4,
    parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    instr_prefetch_buffer_if.master       bus,
    output fetch_state_e                  state_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [INSTR_W-1:0] req_addr_q, req_addr_d;
    logic [INSTR_W-1:0] redirect_word_pc;
    logic               fifo_push;
    logic               instr_valid;
    logic [2*INSTR_W-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;

    assign redirect_word_pc = bus.redirect_pc_i & ~32'h3;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        fifo_push  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Issue only with a free slot, so the returning word always fits.
                if (bus.redirect_i) begin
                    fetch_pc_d = redirect_word_pc;
                end else if (fifo_count < CNT_W'(DEPTH)) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.redirect_i) begin
                    fetch_pc_d = redirect_word_pc;
                    if (bus.mem_ack_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        // The request cannot be withdrawn: keep presenting the
                        // old address and drop its data when it arrives.
                        state_d    = ST_DISCARD;
                        req_addr_d = fetch_pc_q;
                    end
                end else if (bus.mem_ack_i) begin
                    fifo_push  = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    state_d    = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                // A further redirect only retargets; the stale ack still ends DISCARD.
                if (bus.redirect_i) begin
                    fetch_pc_d = redirect_word_pc;
                end
                if (bus.mem_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH (2*INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (bus.redirect_i),
        .push_i      (fifo_push),
        .push_data_i ({fetch_pc_q, bus.mem_data_i}),
        .pop_i       (instr_valid && bus.instr_ready_i),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    // All outputs come from registered state; mem_ack_i never reaches them.
    assign instr_valid       = (fifo_count != '0);
    assign bus.instr_valid_o = instr_valid;
    assign bus.instr_o       = instr_valid ? fifo_head[INSTR_W-1:0] : '0;
    assign bus.instr_pc_o    = instr_valid ? fifo_head[2*INSTR_W-1:INSTR_W] : '0;
    assign bus.mem_req_o     = (state_q == ST_REQ) || (state_q == ST_DISCARD);
    assign bus.mem_addr_o    = (state_q == ST_DISCARD) ? req_addr_q : fetch_pc_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
module tb_instr_prefetch_buffer;
    import instr_prefetch_buffer_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_prefetch_buffer_if bus_if ();
    fetch_state_e dut_state;

    instr_prefetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .bus     (bus_if),
        .state_o (dut_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [31:0] req_log[$];
    int          mem_lat  = 0;
    int          wait_cnt = 0;
    logic        req_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory returns the bitwise inverse of the word address.
    function automatic logic [63:0] fetched(input logic [31:0] pc);
        return {pc, ~pc};
    endfunction

    // ---------------- memory model (drives at posedge+1) ----------------
    always @(posedge clk) begin
        #1;
        if (bus_if.mem_req_o && !req_prev) req_log.push_back(bus_if.mem_addr_o);
        req_prev = bus_if.mem_req_o;
        if (!bus_if.mem_req_o) begin
            bus_if.mem_ack_i  = 1'b0;
            bus_if.mem_data_i = '0;
            wait_cnt          = 0;
        end else if (wait_cnt >= mem_lat) begin
            bus_if.mem_ack_i  = 1'b1;
            bus_if.mem_data_i = ~bus_if.mem_addr_o;
        end else begin
            bus_if.mem_ack_i  = 1'b0;
            bus_if.mem_data_i = '0;
            wait_cnt++;
        end
    end

    // ---------------- pop monitor ----------------
    always @(negedge clk) begin
        if (rst_n && bus_if.instr_valid_o && bus_if.instr_ready_i && !bus_if.redirect_i) begin
            if (exp_q.size() == 0) check("unexpected_pop_qsize", 64'(exp_q.size()), 64'd1);
            else check("pop_pc_instr", {bus_if.instr_pc_o, bus_if.instr_o}, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int lat);
        rst_n                = 1'b0;
        bus_if.redirect_i    = 1'b0;
        bus_if.redirect_pc_i = '0;
        bus_if.instr_ready_i = 1'b0;
        mem_lat              = lat;
        tick();
        tick();
        exp_q.delete();
        req_log.delete();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        bus_if.instr_ready_i = 1'b1;
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        bus_if.instr_ready_i = 1'b0;
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_outs(input string tag, input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, "_req"},   64'(bus_if.mem_req_o),     64'(req));
        check({tag, "_addr"},  64'(bus_if.mem_addr_o),    64'(addr));
        check({tag, "_valid"}, 64'(bus_if.instr_valid_o), 64'(valid));
        check({tag, "_pc"},    64'(bus_if.instr_pc_o),    64'(pc));
        check({tag, "_instr"}, 64'(bus_if.instr_o),       64'(instr));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        bus_if.redirect_i    = 1'b0;
        bus_if.redirect_pc_i = '0;
        bus_if.instr_ready_i = 1'b0;

        // Reset values
        tick();
        tick();
        check_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check("reset_state", 64'(dut_state), 64'(ST_IDLE));

        // 1: zero-wait memory, CPU always ready -> one word per two cycles
        do_reset(0);
        bus_if.instr_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) exp_q.push_back(fetched(32'(4 * k)));
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t1_valid_%0d", i), 64'(bus_if.instr_valid_o), 64'(i % 2 == 1));
            check($sformatf("t1_req_%0d", i),   64'(bus_if.mem_req_o),     64'(i % 2 == 0));
        end
        drain("t1_drain", 20);

        // 2: 3-cycle latency, CPU stalled -> FIFO fills with 4 words and fetch stops
        do_reset(3);
        repeat (30) tick();
        check("t2_nreq", 64'(req_log.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("t2_reqaddr_%0d", k),
                  64'(req_log.size() > k ? req_log[k] : 32'hFFFF_FFFF), 64'(4 * k));
        check_outs("t2_full", 1'b0, 32'h10, 1'b1, 32'h0, 32'hFFFF_FFFF);
        req_log.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(fetched(32'(4 * k)));
        drain("t2_drain", 20);
        for (int i = 0; i < 10 && req_log.size() == 0; i++) tick();
        check("t2_resume_addr", 64'(req_log.size() > 0 ? req_log[0] : 32'hFFFF_FFFF), 64'h10);

        // 3: redirect while idle with 2 entries
        do_reset(0);
        repeat (4) tick();
        check("t3_pre_valid", 64'(bus_if.instr_valid_o), 64'd1);
        check("t3_pre_pc", 64'(bus_if.instr_pc_o), 64'h0);
        bus_if.redirect_i    = 1'b1;
        bus_if.redirect_pc_i = 32'h0000_0103;
        tick();
        bus_if.redirect_i    = 1'b0;
        check_outs("t3_post", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
        exp_q.push_back(fetched(32'h100));
        exp_q.push_back(fetched(32'h104));
        drain("t3_drain", 20);

        // 4: redirect while a request is pending; stale data must never appear
        do_reset(3);
        bus_if.instr_ready_i = 1'b1;
        tick();
        check("t4_req_state", 64'(dut_state), 64'(ST_REQ));
        bus_if.redirect_i    = 1'b1;
        bus_if.redirect_pc_i = 32'h0000_0200;
        tick();
        bus_if.redirect_i    = 1'b0;
        check("t4_discard_state", 64'(dut_state), 64'(ST_DISCARD));
        check_outs("t4_hold1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        check_outs("t4_hold2", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        check_outs("t4_hold3", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        check_outs("t4_dropped", 1'b0, 32'h200, 1'b0, 32'h0, 32'h0);
        check("t4_idle_state", 64'(dut_state), 64'(ST_IDLE));
        tick();
        check_outs("t4_newreq", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
        exp_q.push_back(fetched(32'h200));
        drain("t4_drain", 20);
        check("t4_req1", 64'(req_log.size() > 1 ? req_log[1] : 32'hFFFF_FFFF), 64'h200);

        // 5: redirect coincident with ack and pop
        do_reset(0);
        repeat (5) tick();
        check_outs("t5_pre", 1'b1, 32'h8, 1'b1, 32'h0, 32'hFFFF_FFFF);
        bus_if.redirect_i    = 1'b1;
        bus_if.redirect_pc_i = 32'h0000_0300;
        bus_if.instr_ready_i = 1'b1;
        tick();
        bus_if.redirect_i    = 1'b0;
        bus_if.instr_ready_i = 1'b0;
        check_outs("t5_flushed", 1'b0, 32'h300, 1'b0, 32'h0, 32'h0);
        tick();
        check_outs("t5_newreq", 1'b1, 32'h300, 1'b0, 32'h0, 32'h0);
        exp_q.push_back(fetched(32'h300));
        drain("t5_drain", 20);

        // 6: reset pulse in the middle of a request
        do_reset(1);
        repeat (4) tick();
        check_outs("t6_pre", 1'b1, 32'h4, 1'b1, 32'h0, 32'hFFFF_FFFF);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_outs("t6_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check("t6_reset_state", 64'(dut_state), 64'(ST_IDLE));
        tick();
        check_outs("t6_restart", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        exp_q.push_back(fetched(32'h0));
        drain("t6_drain", 20);

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
